// File: rtl/awg_burst_sequencer.sv
// awg_burst_sequencer
//   Burst-mode controller for the AWG NCO/DAC datapath. After a trigger it
//   lets exactly N complete waveform cycles reach the DAC. N is counted from
//   falling edges of the accumulator MSB. It can optionally re-arm itself
//   after a gap measured in milliseconds.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   trigger      single-cycle start pulse, honoured only in IDLE
//   abort        level; returns to IDLE on the next edge, highest priority
//   auto_repeat  0: one burst per trigger, 1: repeat bursts until abort
//   burst_count  waveform cycles per burst (0 behaves as 1)
//   gap_ms       idle time between auto-repeated bursts, in ms
//   acc_msb      NCO accumulator MSB, before phase offset
//   nco_clear    holds the NCO accumulator at 0
//   out_enable   DAC passes the waveform when 1
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a single-mode burst completes
//   cycles_done  wraps counted in the current burst
//   state_out    IDLE=0, START=1, BURST=2, GAP=3
module awg_burst_sequencer #(
  parameter int CLK_PER_MS = 100000,
  parameter int CNT_W      = 10,
  parameter int GAP_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             abort,
  input  logic             auto_repeat,
  input  logic [CNT_W-1:0] burst_count,
  input  logic [GAP_W-1:0] gap_ms,
  input  logic             acc_msb,
  output logic             nco_clear,
  output logic             out_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles_done,
  output logic [1:0]       state_out
);

  localparam int PS_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_MS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BURST = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_l_q, cnt_l_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [GAP_W-1:0] gap_l_q, gap_l_d;
  logic [GAP_W-1:0] ms_q, ms_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             auto_l_q, auto_l_d;
  logic             done_q, done_d;
  logic             msb_q, msb_d;

  logic             wrap;
  logic             tick;
  logic [CNT_W-1:0] cycles_inc;

  // A wrap is the MSB falling while the accumulator is running. msb_q is held
  // at 0 outside BURST so the first sample after a clear cannot fake an edge.
  assign wrap       = (state_q == BURST) && msb_q && !acc_msb;
  assign tick       = (ps_q == PS_LAST);
  assign cycles_inc = cycles_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_l_d  = cnt_l_q;
    gap_l_d  = gap_l_q;
    auto_l_d = auto_l_q;
    cycles_d = cycles_q;
    ms_d     = ms_q;
    ps_d     = ps_q;
    done_d   = 1'b0;
    msb_d    = (state_q == BURST) ? acc_msb : 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger && !abort) begin
          state_d  = START;
          cnt_l_d  = (burst_count == '0) ? CNT_W'(1) : burst_count;
          gap_l_d  = gap_ms;
          auto_l_d = auto_repeat;
        end
      end
      START: begin
        cycles_d = '0;
        state_d  = BURST;
      end
      BURST: begin
        // The count stops at cnt_l, so it can never wrap inside a burst.
        if (wrap && (cycles_q != cnt_l_q)) begin
          cycles_d = cycles_inc;
          if (cycles_inc == cnt_l_q) begin
            if (!auto_l_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (gap_l_q == '0) begin
              state_d = START;
            end else begin
              state_d = GAP;
              ps_d    = '0;
              ms_d    = '0;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          ps_d = '0;
          ms_d = ms_q + 1'b1;
          if (ms_q == (gap_l_q - 1'b1)) begin
            state_d = START;
          end
        end else begin
          ps_d = ps_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything but leaves the count readable.
    if (abort) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      cycles_d = cycles_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_l_q  <= '0;
      gap_l_q  <= '0;
      auto_l_q <= 1'b0;
      cycles_q <= '0;
      ms_q     <= '0;
      ps_q     <= '0;
      done_q   <= 1'b0;
      msb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_l_q  <= cnt_l_d;
      gap_l_q  <= gap_l_d;
      auto_l_q <= auto_l_d;
      cycles_q <= cycles_d;
      ms_q     <= ms_d;
      ps_q     <= ps_d;
      done_q   <= done_d;
      msb_q    <= msb_d;
    end
  end

  assign nco_clear   = (state_q != BURST);
  assign out_enable  = (state_q == BURST);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign cycles_done = cycles_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_awg_burst_sequencer.sv
module tb_awg_burst_sequencer;

  localparam int CLK_PER_MS = 10;
  localparam int CNT_W      = 10;
  localparam int GAP_W      = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             trigger;
  logic             abort;
  logic             auto_repeat;
  logic [CNT_W-1:0] burst_count;
  logic [GAP_W-1:0] gap_ms;
  logic             acc_msb;
  logic             nco_clear;
  logic             out_enable;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycles_done;
  logic [1:0]       state_out;

  awg_burst_sequencer #(
    .CLK_PER_MS(CLK_PER_MS),
    .CNT_W     (CNT_W),
    .GAP_W     (GAP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger    (trigger),
    .abort      (abort),
    .auto_repeat(auto_repeat),
    .burst_count(burst_count),
    .gap_ms     (gap_ms),
    .acc_msb    (acc_msb),
    .nco_clear  (nco_clear),
    .out_enable (out_enable),
    .busy       (busy),
    .done       (done),
    .cycles_done(cycles_done),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  // Single-burst vectors: inputs {bc, retrig}, expected {exp_n, exp_end}.
  // exp_end is the edge offset from the trigger edge to the done pulse:
  // BURST starts 2 edges after trigger and each 40-clk cycle adds 40.
  typedef struct {
    int bc;
    bit retrig;
    int exp_n;
    int exp_end;
  } vec_t;

  vec_t             vecs[4];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               ph       = 0;
  int               done_cnt = 0;
  int               done_cyc = -1;
  logic             clr_prev;
  logic [CNT_W-1:0] cd_prev  = '0;
  int               q_cd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] e);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, e);
    end
  endtask

  // One clock: advance a 40-clk NCO model (cleared by nco_clear), then
  // score cycles_done changes against the expected queue and log done.
  task automatic step();
    int e;
    clr_prev = nco_clear;
    @(posedge clk);
    #1;
    cyc++;
    ph      = clr_prev ? 0 : (ph + 1) % 40;
    acc_msb = (ph >= 20);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cycles_done != cd_prev && cycles_done != '0) begin
      n_checks++;
      if (q_cd.size() == 0) begin
        n_fail++;
        $display("FAIL cd_unexpected: got %0d expected no further count", cycles_done);
      end else begin
        e = q_cd.pop_front();
        n_checks--;
        check("cd_seq", cycles_done, e);
      end
    end
    cd_prev = cycles_done;
  endtask

  task automatic run_single(input vec_t v);
    int t0;
    burst_count = CNT_W'(v.bc);
    gap_ms      = '0;
    auto_repeat = 1'b0;
    for (int k = 1; k <= v.exp_n; k++) q_cd.push_back(k);
    done_cnt = 0;
    done_cyc = -1;
    trigger  = 1'b1;
    step();
    trigger  = 1'b0;
    t0       = cyc;
    // Changed inputs after the trigger must not affect this burst.
    burst_count = ~CNT_W'(v.bc);
    auto_repeat = 1'b1;
    gap_ms      = GAP_W'(5);
    check("start_state", state_out, 1);
    check("start_clear", nco_clear, 1);
    step();
    check("burst_state", state_out, 2);
    check("burst_oe", out_enable, 1);
    for (int i = 0; i < 400 && done_cyc < 0; i++) begin
      if (v.retrig && cyc == t0 + 20) trigger = 1'b1;
      step();
      trigger = 1'b0;
    end
    check("end_latency", done_cyc - t0, v.exp_end);
    check("end_state", state_out, 0);
    check("end_oe", out_enable, 0);
    check("end_busy", busy, 0);
    check("end_cycles", cycles_done, v.exp_n);
    step();
    check("done_width", done, 0);
    repeat (10) step();
    check("done_count", done_cnt, 1);
    check("queue_empty", q_cd.size(), 0);
    check("idle_hold", state_out, 0);
    q_cd.delete();
    auto_repeat = 1'b0;
    gap_ms      = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   gap_run;
    int   gaps;
    int   ends;
    bit   aborted;
    bit   saw_gap;
    logic [1:0] prev_st;

    vecs[0] = '{bc: 3, retrig: 1'b0, exp_n: 3, exp_end: 122};
    vecs[1] = '{bc: 0, retrig: 1'b1, exp_n: 1, exp_end: 42};
    vecs[2] = '{bc: 1, retrig: 1'b0, exp_n: 1, exp_end: 42};
    vecs[3] = '{bc: 5, retrig: 1'b0, exp_n: 5, exp_end: 202};

    rst_n       = 1'b0;
    trigger     = 1'b0;
    abort       = 1'b0;
    auto_repeat = 1'b0;
    burst_count = '0;
    gap_ms      = '0;
    acc_msb     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state_out, 0);
    check("rst_clear", nco_clear, 1);
    check("rst_oe", out_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cycles", cycles_done, 0);
    rst_n = 1'b1;
    step();

    // Single bursts, zero count and ignored retrigger.
    for (int i = 0; i < 4; i++) run_single(vecs[i]);

    // Auto repeat with a 3 ms gap; abort inside the third gap.
    burst_count = CNT_W'(2);
    gap_ms      = GAP_W'(3);
    auto_repeat = 1'b1;
    repeat (3) begin
      q_cd.push_back(1);
      q_cd.push_back(2);
    end
    done_cnt = 0;
    trigger  = 1'b1;
    step();
    trigger  = 1'b0;
    gap_run  = 0;
    gaps     = 0;
    aborted  = 1'b0;
    prev_st  = state_out;
    for (int i = 0; i < 1000 && !aborted; i++) begin
      step();
      if (state_out == 2'd3) begin
        gap_run++;
        if (gap_run == 1) begin
          check("gap_oe", out_enable, 0);
          check("gap_cycles_hold", cycles_done, 2);
        end
        if (gaps == 2 && gap_run == 5) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          check("gap_abort_state", state_out, 0);
          check("gap_abort_clear", nco_clear, 1);
          check("gap_abort_cycles", cycles_done, 2);
          aborted = 1'b1;
        end
      end else if (prev_st == 2'd3) begin
        gaps++;
        check("gap_len", gap_run, 30);
        check("gap_next", state_out, 1);
        gap_run = 0;
      end
      prev_st = state_out;
    end
    check("gap_aborted", aborted, 1);
    check("gap_count", gaps, 2);
    check("gap_no_done", done_cnt, 0);
    check("gap_queue_empty", q_cd.size(), 0);
    q_cd.delete();
    step();

    // Auto repeat with zero gap: one cleared cycle between bursts.
    burst_count = CNT_W'(1);
    gap_ms      = '0;
    auto_repeat = 1'b1;
    repeat (3) q_cd.push_back(1);
    done_cnt = 0;
    ends     = 0;
    saw_gap  = 1'b0;
    trigger  = 1'b1;
    step();
    trigger  = 1'b0;
    prev_st  = state_out;
    for (int i = 0; i < 400 && ends < 3; i++) begin
      step();
      if (prev_st == 2'd2 && state_out == 2'd1) begin
        ends++;
        check("zg_oe_low", out_enable, 0);
        step();
        check("zg_rearm_state", state_out, 2);
        check("zg_oe_high", out_enable, 1);
      end
      if (state_out == 2'd3) saw_gap = 1'b1;
      prev_st = state_out;
    end
    check("zg_ends", ends, 3);
    check("zg_no_gap", saw_gap, 0);
    check("zg_no_done", done_cnt, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("zg_abort_state", state_out, 0);
    check("zg_queue_empty", q_cd.size(), 0);
    q_cd.delete();
    auto_repeat = 1'b0;

    // Abort mid-BURST after one wrap: count is kept, no done.
    burst_count = CNT_W'(3);
    q_cd.push_back(1);
    done_cnt = 0;
    trigger  = 1'b1;
    step();
    trigger  = 1'b0;
    repeat (50) step();
    check("ab_pre_cycles", cycles_done, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_state", state_out, 0);
    check("ab_oe", out_enable, 0);
    check("ab_cycles", cycles_done, 1);
    repeat (5) step();
    check("ab_no_done", done_cnt, 0);
    check("ab_cycles_hold", cycles_done, 1);

    // Trigger and abort together in IDLE.
    trigger = 1'b1;
    abort   = 1'b1;
    step();
    trigger = 1'b0;
    abort   = 1'b0;
    check("ta_state", state_out, 0);
    check("ta_busy", busy, 0);
    step();
    check("ta_state_hold", state_out, 0);

    // Asynchronous reset in the middle of a burst, between clock edges.
    burst_count = CNT_W'(3);
    q_cd.push_back(1);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (50) step();
    check("ar_pre_oe", out_enable, 1);
    check("ar_pre_cycles", cycles_done, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_clear", nco_clear, 1);
    check("ar_oe", out_enable, 0);
    check("ar_busy", busy, 0);
    check("ar_state", state_out, 0);
    check("ar_cycles", cycles_done, 0);
    check("ar_done", done, 0);
    #2;
    rst_n = 1'b1;
    repeat (3) step();
    check("ar_idle", state_out, 0);
    check("ar_queue_empty", q_cd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/awg_burst_sequencer.md
Name: awg_burst_sequencer

Overview:
Burst-mode controller for the AWG NCO/DAC datapath. It gates the selected waveform so that exactly N complete output cycles are emitted per trigger. It can optionally auto-repeat after a programmable gap in milliseconds. It sits between the button/switch front end and the phase accumulator: it drives the accumulator's clear and the DAC output gate, and counts cycle wraps from the accumulator MSB.

Parameters:
CLK_PER_MS, 100000, system clocks per millisecond (gap timebase); benches use 10.
CNT_W, 10, width of burst-count and cycle-counter fields.
GAP_W, 10, width of gap_ms field.

Ports:
clk  input  1  100 MHz system clock
rst_n  input  1  reset, asynchronous, active-low
trigger  input  1  single-cycle start pulse (debounced button)
abort  input  1  level; forces return to IDLE
auto_repeat  input  1  0: single burst per trigger; 1: repeat bursts until abort
burst_count  input  CNT_W  waveform cycles per burst; 0 treated as 1
gap_ms  input  GAP_W  idle time between auto-repeated bursts, in ms
acc_msb  input  1  bit 31 of the NCO accumulator, before phase offset
nco_clear  output  1  holds/clears NCO accumulator to 0
out_enable  output  1  1: DAC passes waveform; 0: DAC forced to midscale by consumer
busy  output  1  1 in any state except IDLE
done  output  1  one-cycle pulse when a single-mode burst completes
cycles_done  output  CNT_W  wraps counted in the current burst
state_out  output  2  IDLE=0, START=1, BURST=2, GAP=3

Behaviour:
- Reset (async, rst_n=0): state=IDLE, nco_clear=1, out_enable=0, busy=0, done=0, cycles_done=0, prescaler=0, ms counter=0, msb_d=0.
- Moore outputs are decoded from the registered state:
  - IDLE: nco_clear=1, out_enable=0
  - START: nco_clear=1, out_enable=0
  - BURST: nco_clear=0, out_enable=1
  - GAP: nco_clear=1, out_enable=0
- busy=(state!=IDLE).
- Wrap event: acc_msb_d=1 and acc_msb=0 (falling edge). msb_d is registered every cycle and forced to 0 while in IDLE, START, or GAP.
- IDLE:
  - trigger=1 and abort=0 -> START.
  - On that edge, latch cnt_l = (burst_count==0 ? 1 : burst_count), gap_l = gap_ms, auto_l = auto_repeat.
  - Inputs are not resampled until the next IDLE->START.
- START: lasts exactly one cycle; cycles_done<=0 -> BURST.
- BURST:
  - On a wrap, cycles_done<=cycles_done+1.
  - If cycles_done+1==cnt_l, the burst ends:
    - auto_l=0 -> IDLE, and done=1 for one cycle (registered, same edge as the state change).
    - auto_l=1, gap_l==0 -> START (back-to-back bursts; one cleared cycle between them).
    - auto_l=1, gap_l!=0 -> GAP; prescaler<=0, ms<=0.
- GAP:
  - The prescaler counts 0..CLK_PER_MS-1; its terminal count is a tick.
  - On a tick, ms<=ms+1. When ms==gap_l-1 and tick -> START.
  - GAP length is exactly gap_l*CLK_PER_MS cycles.
  - cycles_done holds its final value through GAP.
- Latency:
  - trigger sampled at edge T -> START at T+1 -> BURST at T+2 (out_enable=1).
  - Final wrap detected at edge W -> out_enable=0 at W+1.
- trigger while busy: ignored, no retrigger or queuing.
- abort=1: any state -> IDLE on the next edge, and has priority over every other transition. No done pulse. cycles_done is kept for readout.
- trigger and abort in the same cycle in IDLE: remain in IDLE.
- cycles_done saturation: cannot exceed cnt_l; it never wraps within a burst.
- rst_n asserted mid-burst: outputs take their reset values immediately (asynchronous).

Test Plan:
1. Reset: rst_n=0 mid-BURST -> nco_clear=1, out_enable=0, busy=0, state_out=0 with no clock edge required.
2. Single burst: burst_count=3, auto_repeat=0, acc_msb square with period 40 clk. Pulse trigger -> START 1 cycle, then out_enable=1. cycles_done steps 1,2,3. After the 3rd falling edge, out_enable=0, done=1 for one cycle, state IDLE.
3. Zero count and retrigger: burst_count=0 -> exactly 1 wrap counted then IDLE. A second trigger pulse during BURST is ignored; cycles_done never exceeds 1.
4. Auto repeat with gap: CLK_PER_MS=10, burst_count=2, gap_ms=3, auto_repeat=1 -> BURST, then GAP lasting exactly 30 clk with out_enable=0, then START, then BURST. Repeats 3 times; done stays 0.
5. Auto, zero gap: gap_ms=0 -> after the final wrap, state goes BURST->START->BURST. out_enable is low for exactly 1 cycle.
6. Abort: abort=1 during GAP, and separately during BURST with cycles_done=1 -> IDLE next edge, no done pulse, cycles_done holds 1. trigger+abort together in IDLE -> stays IDLE.
